// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields, holds them across load-use
// stalls with write-back snooping, flushes to a bubble, and counts stalled cycles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_valid,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [XLEN-1:0]  ID_rs1_data,
    input  logic [XLEN-1:0]  ID_rs2_data,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic [6:0]       ID_opcode,
    input  logic [2:0]       ID_funct3,
    input  logic [6:0]       ID_funct7,
    input  logic             ID_regwrite,
    input  logic             ID_memtoreg,
    input  logic             ID_memwrite,
    input  logic             ID_alusrc,
    input  logic             ID_branch,
    input  logic             EX_stall,
    input  logic             EX_flush,
    input  logic [4:0]       WB_rd,
    input  logic [XLEN-1:0]  WB_result,
    input  logic             WB_regwrite,
    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic [XLEN-1:0]  ID_EX_rs1_data,
    output logic [XLEN-1:0]  ID_EX_rs2_data,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [6:0]       ID_EX_opcode,
    output logic [2:0]       ID_EX_funct3,
    output logic [6:0]       ID_EX_funct7,
    output logic             ID_EX_regwrite,
    output logic             ID_EX_memtoreg,
    output logic             ID_EX_memwrite,
    output logic             ID_EX_alusrc,
    output logic             ID_EX_branch,
    output logic             ID_hold,
    output logic             EX_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        sat_inc = (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic            stall_p0;
    logic            wb_hit_p0;
    logic [4:0]      rs1_idx_p0;
    logic [4:0]      rs2_idx_p0;
    logic [XLEN-1:0] rs1_data_p0;
    logic [XLEN-1:0] rs2_data_p0;

    // Stage p0: mode decode and operand snoop against the index being stored
    always_comb begin
        stall_p0    = EX_stall & ~EX_flush;
        wb_hit_p0   = WB_regwrite && (WB_rd != 5'd0);
        rs1_idx_p0  = EX_stall ? ID_EX_rs1 : ID_rs1;
        rs2_idx_p0  = EX_stall ? ID_EX_rs2 : ID_rs2;
        rs1_data_p0 = EX_stall ? ID_EX_rs1_data : ID_rs1_data;
        rs2_data_p0 = EX_stall ? ID_EX_rs2_data : ID_rs2_data;
        if (wb_hit_p0 && (WB_rd == rs1_idx_p0)) rs1_data_p0 = WB_result;
        if (wb_hit_p0 && (WB_rd == rs2_idx_p0)) rs2_data_p0 = WB_result;
    end

    assign ID_hold   = stall_p0;
    assign EX_bubble = stall_p0;

    // Stage p1: the ID/EX register itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_opcode   <= '0;
            ID_EX_funct3   <= '0;
            ID_EX_funct7   <= '0;
            ID_EX_regwrite <= 1'b0;
            ID_EX_memtoreg <= 1'b0;
            ID_EX_memwrite <= 1'b0;
            ID_EX_alusrc   <= 1'b0;
            ID_EX_branch   <= 1'b0;
            stall_cycles   <= '0;
        end else if (EX_flush) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_opcode   <= '0;
            ID_EX_funct3   <= '0;
            ID_EX_funct7   <= '0;
            ID_EX_regwrite <= 1'b0;
            ID_EX_memtoreg <= 1'b0;
            ID_EX_memwrite <= 1'b0;
            ID_EX_alusrc   <= 1'b0;
            ID_EX_branch   <= 1'b0;
        end else if (EX_stall) begin
            ID_EX_rs1_data <= rs1_data_p0;
            ID_EX_rs2_data <= rs2_data_p0;
            if (ID_EX_valid) stall_cycles <= sat_inc(stall_cycles);
        end else begin
            ID_EX_valid    <= ID_valid;
            ID_EX_pc       <= ID_pc;
            ID_EX_imm      <= ID_imm;
            ID_EX_rs1_data <= rs1_data_p0;
            ID_EX_rs2_data <= rs2_data_p0;
            ID_EX_rs1      <= ID_rs1;
            ID_EX_rs2      <= ID_rs2;
            ID_EX_rd       <= ID_rd;
            ID_EX_opcode   <= ID_opcode;
            ID_EX_funct3   <= ID_funct3;
            ID_EX_funct7   <= ID_funct7;
            // A bubble must not write anything, and x0 is never a destination
            ID_EX_regwrite <= ID_regwrite & ID_valid & (ID_rd != 5'd0);
            ID_EX_memtoreg <= ID_memtoreg & ID_valid;
            ID_EX_memwrite <= ID_memwrite & ID_valid;
            ID_EX_alusrc   <= ID_alusrc;
            ID_EX_branch   <= ID_branch & ID_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: load, x0 guard, snoops, flush priority,
// counter saturation and asynchronous reset.
module tb_id_ex_stage_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ID_valid;
    logic [XLEN-1:0]  ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
    logic [4:0]       ID_rs1, ID_rs2, ID_rd;
    logic [6:0]       ID_opcode, ID_funct7;
    logic [2:0]       ID_funct3;
    logic             ID_regwrite, ID_memtoreg, ID_memwrite, ID_alusrc, ID_branch;
    logic             EX_stall, EX_flush;
    logic [4:0]       WB_rd;
    logic [XLEN-1:0]  WB_result;
    logic             WB_regwrite;
    logic             ID_EX_valid;
    logic [XLEN-1:0]  ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data;
    logic [4:0]       ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [6:0]       ID_EX_opcode, ID_EX_funct7;
    logic [2:0]       ID_EX_funct3;
    logic             ID_EX_regwrite, ID_EX_memtoreg, ID_EX_memwrite, ID_EX_alusrc, ID_EX_branch;
    logic             ID_hold, EX_bubble;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid),
        .ID_pc(ID_pc), .ID_imm(ID_imm), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_opcode(ID_opcode), .ID_funct3(ID_funct3), .ID_funct7(ID_funct7),
        .ID_regwrite(ID_regwrite), .ID_memtoreg(ID_memtoreg), .ID_memwrite(ID_memwrite),
        .ID_alusrc(ID_alusrc), .ID_branch(ID_branch),
        .EX_stall(EX_stall), .EX_flush(EX_flush),
        .WB_rd(WB_rd), .WB_result(WB_result), .WB_regwrite(WB_regwrite),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7(ID_EX_funct7),
        .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memtoreg(ID_EX_memtoreg),
        .ID_EX_memwrite(ID_EX_memwrite), .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_branch(ID_EX_branch),
        .ID_hold(ID_hold), .EX_bubble(EX_bubble), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic vld, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [31:0] d1, input logic [4:0] rs2,
                               input logic [31:0] d2, input logic [4:0] rd, input logic rw);
        ID_valid    = vld;
        ID_pc       = pc;
        ID_imm      = pc + 32'h4;
        ID_rs1      = rs1;
        ID_rs1_data = d1;
        ID_rs2      = rs2;
        ID_rs2_data = d2;
        ID_rd       = rd;
        ID_regwrite = rw;
        ID_opcode   = 7'h33;
        ID_funct3   = 3'h1;
        ID_funct7   = 7'h20;
        ID_memtoreg = 1'b1;
        ID_memwrite = 1'b1;
        ID_alusrc   = 1'b1;
        ID_branch   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        EX_stall = 1'b0; EX_flush = 1'b0;
        WB_rd = 5'd0; WB_result = '0; WB_regwrite = 1'b0;
        drive_instr(1'b1, 32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 5'd5, 1'b1);

        // Reset state before any clock edge
        #3;
        chk("rst_valid", 64'(ID_EX_valid), 64'd0);
        chk("rst_rd", 64'(ID_EX_rd), 64'd0);
        chk("rst_cnt", 64'(stall_cycles), 64'd0);
        #9 rst_n = 1'b1;

        // Plain load
        tick();
        chk("load_rd", 64'(ID_EX_rd), 64'd5);
        chk("load_rs1_data", 64'(ID_EX_rs1_data), 64'h11);
        chk("load_valid", 64'(ID_EX_valid), 64'd1);
        chk("load_pc", 64'(ID_EX_pc), 64'h100);
        chk("load_imm", 64'(ID_EX_imm), 64'h104);
        chk("load_funct7", 64'(ID_EX_funct7), 64'h20);
        chk("load_regwrite", 64'(ID_EX_regwrite), 64'd1);
        chk("load_branch", 64'(ID_EX_branch), 64'd1);

        // x0 destination
        drive_instr(1'b1, 32'h104, 5'd1, 32'h11, 5'd2, 32'h22, 5'd0, 1'b1);
        tick();
        chk("x0_regwrite", 64'(ID_EX_regwrite), 64'd0);
        chk("x0_memwrite", 64'(ID_EX_memwrite), 64'd1);

        // Invalid decode slot clears side-effecting controls
        drive_instr(1'b0, 32'h108, 5'd1, 32'h11, 5'd2, 32'h22, 5'd5, 1'b1);
        tick();
        chk("inv_valid", 64'(ID_EX_valid), 64'd0);
        chk("inv_regwrite", 64'(ID_EX_regwrite), 64'd0);
        chk("inv_memwrite", 64'(ID_EX_memwrite), 64'd0);
        chk("inv_memtoreg", 64'(ID_EX_memtoreg), 64'd0);
        chk("inv_branch", 64'(ID_EX_branch), 64'd0);
        chk("inv_alusrc", 64'(ID_EX_alusrc), 64'd1);
        chk("inv_pc", 64'(ID_EX_pc), 64'h108);

        // Stall with rs2 snoop in the second stall cycle
        drive_instr(1'b1, 32'h200, 5'd6, 32'h66, 5'd7, 32'h22, 5'd9, 1'b1);
        tick();
        EX_stall = 1'b1;
        drive_instr(1'b1, 32'h300, 5'd1, 32'h77, 5'd7, 32'h88, 5'd3, 1'b0);
        #1;
        chk("stall_hold_c1", 64'(ID_hold), 64'd1);
        chk("stall_bubble_c1", 64'(EX_bubble), 64'd1);
        tick();
        chk("stall_rs2_c1", 64'(ID_EX_rs2_data), 64'h22);
        WB_rd = 5'd7; WB_result = 32'hABCD; WB_regwrite = 1'b1;
        #1;
        chk("stall_hold_c2", 64'(ID_hold), 64'd1);
        tick();
        WB_regwrite = 1'b0;
        #1;
        chk("stall_bubble_c3", 64'(EX_bubble), 64'd1);
        tick();
        chk("stall_rs2_data", 64'(ID_EX_rs2_data), 64'hABCD);
        chk("stall_rs1_data", 64'(ID_EX_rs1_data), 64'h66);
        chk("stall_rd", 64'(ID_EX_rd), 64'd9);
        chk("stall_pc", 64'(ID_EX_pc), 64'h200);
        chk("stall_cnt", 64'(stall_cycles), 64'd3);
        EX_stall = 1'b0;
        #1;
        chk("unstall_hold", 64'(ID_hold), 64'd0);

        // Load-mode snoop: hit, then WB_rd = 0, then WB_regwrite = 0
        drive_instr(1'b1, 32'h400, 5'd3, 32'h1, 5'd4, 32'h2, 5'd8, 1'b1);
        WB_rd = 5'd3; WB_result = 32'h99; WB_regwrite = 1'b1;
        tick();
        chk("lsnoop_hit", 64'(ID_EX_rs1_data), 64'h99);
        chk("lsnoop_rs2", 64'(ID_EX_rs2_data), 64'h2);
        WB_rd = 5'd0;
        tick();
        chk("lsnoop_x0", 64'(ID_EX_rs1_data), 64'h1);
        WB_rd = 5'd3; WB_regwrite = 1'b0;
        tick();
        chk("lsnoop_nowe", 64'(ID_EX_rs1_data), 64'h1);

        // Flush wins over stall
        EX_flush = 1'b1; EX_stall = 1'b1;
        #1;
        chk("flush_hold", 64'(ID_hold), 64'd0);
        chk("flush_bubble", 64'(EX_bubble), 64'd0);
        tick();
        chk("flush_valid", 64'(ID_EX_valid), 64'd0);
        chk("flush_rd", 64'(ID_EX_rd), 64'd0);
        chk("flush_rs1_data", 64'(ID_EX_rs1_data), 64'd0);
        chk("flush_pc", 64'(ID_EX_pc), 64'd0);
        chk("flush_alusrc", 64'(ID_EX_alusrc), 64'd0);
        chk("flush_cnt", 64'(stall_cycles), 64'd3);

        // Stalling a bubble does not count
        EX_flush = 1'b0;
        tick();
        chk("bubble_stall_cnt", 64'(stall_cycles), 64'd3);

        // Saturation: bring counter to 0xFFFE, then stall 3 more
        EX_stall = 1'b0;
        drive_instr(1'b1, 32'h500, 5'd1, 32'h5, 5'd2, 32'h6, 5'd10, 1'b1);
        tick();
        EX_stall = 1'b1;
        for (int i = 0; i < 16'hFFFE - 3; i++) @(posedge clk);
        #1;
        chk("sat_pre", 64'(stall_cycles), 64'hFFFE);
        tick();
        chk("sat_first", 64'(stall_cycles), 64'hFFFF);
        tick();
        tick();
        chk("sat_hold", 64'(stall_cycles), 64'hFFFF);

        // Asynchronous reset mid-stall, between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(stall_cycles), 64'd0);
        chk("arst_valid", 64'(ID_EX_valid), 64'd0);
        chk("arst_pc", 64'(ID_EX_pc), 64'd0);
        chk("arst_rs1_data", 64'(ID_EX_rs1_data), 64'd0);
        EX_stall = 1'b0;
        drive_instr(1'b1, 32'h600, 5'd1, 32'h31, 5'd2, 32'h32, 5'd12, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_pc", 64'(ID_EX_pc), 64'h600);
        chk("post_rst_rd", 64'(ID_EX_rd), 64'd12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
